// File: rtl/buffer_reader_if.sv
// ---------------------------------------------------------------------------
// buffer_reader_if
// Bundles the buffer read port, the control inputs and the display-side
// outputs of buffer_reader.
//   master : the surrounding system (drives en/update/buf_empty/buf_dout,
//            observes buf_rd and the display outputs)
//   slave  : buffer_reader itself
// Signals:
//   en           read enable; while low no new pops are issued
//   update       single-cycle request to advance to the next word
//   buf_empty    buffer has no words
//   buf_dout     buffer read data, valid the cycle after buf_rd
//   buf_rd       single-cycle pop strobe
//   data_2       word currently displayed
//   data_2_valid data_2 holds a live word
//   parity       even parity (XOR reduction) of data_2
//   words_read   count of words popped, wraps 255 -> 0
// ---------------------------------------------------------------------------
interface buffer_reader_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic              en;
  logic              update;
  logic              buf_empty;
  logic [DATA_W-1:0] buf_dout;
  logic              buf_rd;
  logic [DATA_W-1:0] data_2;
  logic              data_2_valid;
  logic              parity;
  logic [7:0]        words_read;

  modport master (
    output en,
    output update,
    output buf_empty,
    output buf_dout,
    input  buf_rd,
    input  data_2,
    input  data_2_valid,
    input  parity,
    input  words_read
  );

  modport slave (
    input  en,
    input  update,
    input  buf_empty,
    input  buf_dout,
    output buf_rd,
    output data_2,
    output data_2_valid,
    output parity,
    output words_read
  );

endinterface : buffer_reader_if

// File: rtl/buffer_reader.sv
// ---------------------------------------------------------------------------
// buffer_reader
// Read-side consumer of the shared data buffer. Pops one word at a time and
// holds it on data_2 for HOLD_CYCLES clocks (or until an update pulse), with
// data_2_valid asserted. data_2_valid only falls when the block returns to
// IDLE, so a drain is complete once the buffer is empty and valid is low.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  buffer_reader_if.slave (see interface file for signal list)
// All outputs on bus are registered.
// ---------------------------------------------------------------------------
module buffer_reader #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned HOLD_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  buffer_reader_if.slave   bus
);

  localparam int unsigned    WR_W    = 8;
  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_buf_rd;
  logic [DATA_W-1:0] r_data_2;
  logic              r_valid;
  logic              r_parity;
  logic [WR_W-1:0]   r_words_read;

  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_buf_rd_nxt;
  logic [DATA_W-1:0] w_data_2_nxt;
  logic              w_valid_nxt;
  logic              w_parity_nxt;
  logic [WR_W-1:0]   w_words_read_nxt;

  logic              w_go;
  logic              w_advance;

  // A new pop may be issued only when enabled and the buffer has data.
  assign w_go = bus.en & ~bus.buf_empty;

  // Terminal count and update together still produce a single advance.
  assign w_advance = (r_state == HOLD) & ((r_cnt == LP_TERM) | bus.update);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_next_state = READ;
        end
      end
      READ: begin
        w_next_state = LATCH;
      end
      LATCH: begin
        w_next_state = HOLD;
      end
      HOLD: begin
        if (w_advance) begin
          w_next_state = w_go ? READ : IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_data_2_nxt     = r_data_2;
    w_parity_nxt     = r_parity;
    w_valid_nxt      = r_valid;
    w_words_read_nxt = r_words_read;
    // buf_rd is high exactly while in READ, so it is registered on entry.
    w_buf_rd_nxt     = (w_next_state == READ);

    if (w_buf_rd_nxt) begin
      w_words_read_nxt = r_words_read + WR_W'(1);
    end

    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
      end
      LATCH: begin
        w_data_2_nxt = bus.buf_dout;
        w_parity_nxt = ^bus.buf_dout;
        w_valid_nxt  = 1'b1;
        w_cnt_nxt    = '0;
      end
      HOLD: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // Valid stays high across back-to-back words; drops only into IDLE.
        if (w_advance && !w_go) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_buf_rd     <= 1'b0;
      r_data_2     <= '0;
      r_valid      <= 1'b0;
      r_parity     <= 1'b0;
      r_words_read <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_buf_rd     <= w_buf_rd_nxt;
      r_data_2     <= w_data_2_nxt;
      r_valid      <= w_valid_nxt;
      r_parity     <= w_parity_nxt;
      r_words_read <= w_words_read_nxt;
    end
  end

  assign bus.buf_rd       = r_buf_rd;
  assign bus.data_2       = r_data_2;
  assign bus.data_2_valid = r_valid;
  assign bus.parity       = r_parity;
  assign bus.words_read   = r_words_read;

endmodule : buffer_reader

// File: tb/tb_buffer_reader.sv
// ---------------------------------------------------------------------------
// tb_buffer_reader
// Directed bench for buffer_reader with HOLD_CYCLES=4. A simple buffer model
// returns popped data the cycle after buf_rd. Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_buffer_reader;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned HOLD   = 4;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  buffer_reader_if #(.DATA_W(DATA_W)) bus ();

  buffer_reader #(
    .DATA_W      (DATA_W),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Buffer model
  logic [DATA_W-1:0] mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.buf_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.buf_rd === 1'b1 && rd_ptr != wr_ptr) begin
      bus.buf_dout <= mem[rd_ptr[8:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Protocol monitor: no pop decided on an empty buffer, no back-to-back pops
  logic s_empty = 1'b1;
  logic last_rd = 1'b0;
  int   viol    = 0;

  always @(posedge clk) s_empty <= bus.buf_empty;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      viol <= viol + ((bus.buf_rd === 1'b1 && s_empty) ? 1 : 0)
                   + ((bus.buf_rd === 1'b1 && last_rd) ? 1 : 0);
    end
    last_rd <= (bus.buf_rd === 1'b1);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    mem[wr_ptr[8:0]] = w;
    wr_ptr++;
  endtask

  task automatic wait_valid(input logic want, input int budget, input string tag);
    int k = 0;
    while (bus.data_2_valid !== want && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bus.data_2_valid === want), 32'd1);
  endtask

  initial begin
    bus.en     = 1'b0;
    bus.update = 1'b0;
    rst        = 1'b1;
    #1 rst     = 1'b0;
    step(2);

    // Reset state
    chk("rst_data2",  32'(bus.data_2),       32'h0);
    chk("rst_valid",  32'(bus.data_2_valid), 32'h0);
    chk("rst_words",  32'(bus.words_read),   32'h0);
    chk("rst_buf_rd", 32'(bus.buf_rd),       32'h0);
    chk("rst_parity", 32'(bus.parity),       32'h0);
    rst = 1'b1;
    step(1);

    // Reset asserted asynchronously mid-HOLD
    push(16'h00A5);
    bus.en = 1'b1;
    step(3);
    chk("a5_data",   32'(bus.data_2),       32'h00A5);
    chk("a5_parity", 32'(bus.parity),       32'h0);
    chk("a5_valid",  32'(bus.data_2_valid), 32'h1);
    step(1);
    #2 rst = 1'b0;
    #1;
    chk("async_data2",  32'(bus.data_2),       32'h0);
    chk("async_valid",  32'(bus.data_2_valid), 32'h0);
    chk("async_words",  32'(bus.words_read),   32'h0);
    chk("async_buf_rd", 32'(bus.buf_rd),       32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(3);
    chk("idle_empty_valid",  32'(bus.data_2_valid), 32'h0);
    chk("idle_empty_buf_rd", 32'(bus.buf_rd),       32'h0);
    chk("idle_empty_words",  32'(bus.words_read),   32'h0);

    // Two words, full holds
    push(16'h1234);
    push(16'h0007);
    step(1);
    chk("t2_rd1",       32'(bus.buf_rd),       32'h1);
    chk("t2_rd1_valid", 32'(bus.data_2_valid), 32'h0);
    step(1);
    chk("t2_latch_rd",  32'(bus.buf_rd),       32'h0);
    step(1);
    chk("t2_w0_data",   32'(bus.data_2),       32'h1234);
    chk("t2_w0_parity", 32'(bus.parity),       32'h1);
    chk("t2_w0_valid",  32'(bus.data_2_valid), 32'h1);
    chk("t2_w0_words",  32'(bus.words_read),   32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_hold_rd", 32'(bus.buf_rd), 32'h0);
    end
    step(1);
    chk("t2_rd2",       32'(bus.buf_rd),       32'h1);
    chk("t2_rd2_valid", 32'(bus.data_2_valid), 32'h1);
    step(2);
    chk("t2_w1_data",   32'(bus.data_2),       32'h0007);
    chk("t2_w1_parity", 32'(bus.parity),       32'h1);
    step(3);
    chk("t2_w1_last_valid", 32'(bus.data_2_valid), 32'h1);
    step(1);
    chk("t2_drop_valid", 32'(bus.data_2_valid), 32'h0);
    chk("t2_words",      32'(bus.words_read),   32'h2);

    // Single word cut short by update, buffer empty
    push(16'h00FF);
    step(3);
    chk("t3_data",   32'(bus.data_2),       32'h00FF);
    chk("t3_parity", 32'(bus.parity),       32'h0);
    chk("t3_valid",  32'(bus.data_2_valid), 32'h1);
    bus.update = 1'b1;
    step(1);
    bus.update = 1'b0;
    chk("t3_upd_valid",  32'(bus.data_2_valid), 32'h0);
    chk("t3_upd_buf_rd", 32'(bus.buf_rd),       32'h0);
    step(3);
    chk("t3_words", 32'(bus.words_read), 32'h3);
    // update in IDLE is ignored
    bus.update = 1'b1;
    step(1);
    bus.update = 1'b0;
    step(2);
    chk("t3_idle_upd_valid", 32'(bus.data_2_valid), 32'h0);
    chk("t3_idle_upd_words", 32'(bus.words_read),   32'h3);

    // Update coincident with terminal count: one advance only
    push(16'h0101);
    push(16'h0202);
    push(16'h0303);
    step(3);
    chk("t4_w0_data", 32'(bus.data_2), 32'h0101);
    step(3);
    bus.update = 1'b1;
    step(1);
    bus.update = 1'b0;
    chk("t4_rd",        32'(bus.buf_rd), 32'h1);
    step(1);
    chk("t4_latch_rd",  32'(bus.buf_rd), 32'h0);
    step(1);
    chk("t4_w1_data",   32'(bus.data_2),       32'h0202);
    chk("t4_w1_parity", 32'(bus.parity),       32'h0);
    chk("t4_w1_valid",  32'(bus.data_2_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t4_w1_hold_rd", 32'(bus.buf_rd), 32'h0);
    end
    step(1);
    chk("t4_rd_after_full_hold", 32'(bus.buf_rd),     32'h1);
    chk("t4_words",              32'(bus.words_read), 32'h6);
    wait_valid(1'b0, 20, "t4_drain_timeout");
    chk("t4_last_data", 32'(bus.data_2), 32'h0303);

    // en dropped during the hold of the first of two words
    push(16'h0011);
    push(16'h0022);
    step(3);
    chk("t5_w0_data", 32'(bus.data_2), 32'h0011);
    step(1);
    bus.en = 1'b0;
    step(2);
    chk("t5_hold_valid", 32'(bus.data_2_valid), 32'h1);
    step(1);
    chk("t5_idle_valid",  32'(bus.data_2_valid), 32'h0);
    chk("t5_idle_buf_rd", 32'(bus.buf_rd),       32'h0);
    step(3);
    chk("t5_still_idle_valid", 32'(bus.data_2_valid), 32'h0);
    chk("t5_words",            32'(bus.words_read),   32'h7);
    bus.en = 1'b1;
    step(1);
    chk("t5_reen_rd", 32'(bus.buf_rd), 32'h1);
    step(2);
    chk("t5_w1_data",  32'(bus.data_2),       32'h0022);
    chk("t5_w1_valid", 32'(bus.data_2_valid), 32'h1);
    chk("t5_w1_words", 32'(bus.words_read),   32'h8);
    wait_valid(1'b0, 20, "t5_drain_timeout");

    // 256-word stream from a fresh reset: words_read wraps to 0
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("t6_rst_words", 32'(bus.words_read), 32'h0);
    for (int i = 0; i < 256; i++) begin
      push(16'(i * 3 + 1));
    end
    wait_valid(1'b1, 10, "t6_start_timeout");
    chk("t6_first_data", 32'(bus.data_2), 32'h0001);
    wait_valid(1'b0, 2000, "t6_drain_timeout");
    chk("t6_words_wrap", 32'(bus.words_read), 32'h0);
    chk("t6_last_data",  32'(bus.data_2),     32'h02FE);
    chk("t6_last_par",   32'(bus.parity),     32'h0);
    chk("t6_drained",    32'(rd_ptr == wr_ptr), 32'h1);
    step(2);
    chk("protocol_violations", 32'(viol), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_buffer_reader
